sqn_allocator: RTL and testbench
================================

# sqn_allocator

Parametrised sequence-number allocator for the rename stage. It assigns ROB, load-queue and store-queue sequence numbers to up to `WIDTH` decoded ops per cycle across `NUM_CH` independent channels. It tracks per-channel occupancy against committed/retired counts and back-pressures the front end when any channel would overflow its queue. It restores all channel counters on a branch flush.

## Interface
Parameters:
- `WIDTH`, 4: issue lanes per cycle.
- `NUM_CH`, 3: channel count (0 = ROB, 1 = load, 2 = store by convention).
- `SQN_W`, 7: sequence-number width, shared by all channels.
- `DEPTH`, 64: entries per channel queue. Must satisfy `DEPTH <= 2**(SQN_W-1)`.
- `PRE_INC`, `NUM_CH'b100`: per-channel mode.
  - Bit set: the lane receives the post-increment value (pre-increment numbering).
  - Bit clear: the lane receives the current value.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `IN_en` in 1: front end offers a group this cycle.
- `IN_valid` in `WIDTH`: per-lane op valid.
- `IN_chMask` in `WIDTH×NUM_CH`: lane i consumes one entry of channel c.
- `IN_extStall` in 1: downstream stall (issue-queue full etc.).
- `IN_retire` in `NUM_CH×$clog2(WIDTH+1)`: entries freed per channel this cycle.
- `IN_flush` in 1: mispredict flush.
- `IN_flushSqN` in `NUM_CH×SQN_W`: restored next-allocation value per channel.
- `OUT_stall` in→out 1: group not accepted this cycle (combinational).
- `OUT_valid` out `WIDTH`: registered per-lane valid of the accepted group.
- `OUT_sqN` out `WIDTH×NUM_CH×SQN_W`: registered assigned numbers.
- `OUT_next` out `NUM_CH×SQN_W`: registered next-allocation value per channel.
- `OUT_free` out `NUM_CH×$clog2(DEPTH+1)`: registered free entries per channel.

## Operation
- Per channel c the block holds `alloc[c]` (next number) and `head[c]` (oldest live).
  - `inflight = alloc - head`, computed mod `2**SQN_W`.
  - `free = DEPTH - inflight`.
- Demand: `need[c] = count of lanes with IN_valid[i] && IN_chMask[i][c]`.
- `OUT_stall = IN_flush || IN_extStall || (IN_en && any need[c] > free[c])`.
- Accept condition: `fire = IN_en && !OUT_stall`. Acceptance is all-or-nothing for the group; there is no partial issue.
- Lane numbering is a prefix sum over lanes `0..i-1`: `base = alloc[c] + prefix(i)`.
  - `PRE_INC[c]` set: the lane gets `base + 1` when it consumes c, else `base`.
  - `PRE_INC[c]` clear: the lane gets `base`.
  - Lanes that do not consume c still receive the current value; this is the ordering tag for that channel.
- On fire: `alloc[c] += need[c]`. `OUT_valid` becomes `IN_valid` and `OUT_sqN` is updated. Without fire, `OUT_valid` is 0 and `OUT_sqN` holds.
- Retire: `head[c] += IN_retire[c]` every cycle, including flush cycles.
- Flush: `alloc[c] <= IN_flushSqN[c]` and `OUT_valid <= 0`, overriding any fire.
- All arithmetic wraps mod `2**SQN_W`. Ordering comparisons use the signed difference.

## Timing
- Reset values:
  - `alloc`, `head`, `OUT_next` = 0.
  - `OUT_free` = `DEPTH`.
  - `OUT_valid` = 0; `OUT_sqN` = 0.
  - `OUT_stall` reflects its inputs combinationally; it is 1 during a flush.
- Latency: one cycle from an accepted `IN_*` to `OUT_valid`/`OUT_sqN`.
- Freed credits become visible one cycle after the `IN_retire` cycle. Same-cycle retire does not relieve that cycle's stall.
- Flush and fire in the same cycle: flush wins and the group is dropped.
- Flush and retire in the same cycle: both apply.
- Exactly full (`need == free`): the group is accepted, and free becomes 0.
- Wrap-around: `alloc` passing `2**SQN_W - 1 -> 0` is legal. `inflight` stays correct modulo.
- `IN_retire[c] > inflight[c]` or `inflight > DEPTH` after a flush is illegal. Simulation asserts on it.
- Reset mid-group: the pending group is discarded and all state returns to its reset values.

## Structure
- Shared package: `SqN` typedef (`SQN_W`), channel index constants `CH_ROB`, `CH_LD`, `CH_ST`, and a `SqnGroup_t` struct for the per-lane number vector.
- Sub-module `sqn_channel_ctr`, instantiated once per channel. It holds `alloc`/`head`, the prefix-sum numbering, free computation, and flush/retire update.
- The top level handles only stall reduction, the fire decision and output registers.

## Test plan
- **Reset then group:** after `rst`, issue 4 lanes, all with ROB, lanes 1–2 with load, lane 3 with store.
  - Next cycle ROB numbers = 0,1,2,3 and load numbers = 0,0,1,2.
  - Store (`PRE_INC`) numbers = 0,0,0,1 and `OUT_next` = {4,2,1}.
- **Full boundary:** `DEPTH`=64, 62 inflight on ROB, 2-lane group → accepted and `OUT_free`=0. A further 1-lane group → `OUT_stall`=1 and `alloc` is unchanged.
- **Retire visibility:** full ROB plus `IN_retire`=2 with a 1-lane group → stalled that cycle, accepted the next.
- **Flush priority:** fire and `IN_flush` with `IN_flushSqN`={10,3,5} in the same cycle → `OUT_valid`=0 and next `OUT_next`={10,3,5}. Then a 1-lane ROB op gets 10.
- **Wrap:** `SQN_W`=7, `alloc`=126, head=100, 4-lane ROB group → numbers 126,127,0,1, `alloc`=2, `OUT_free`=34.
- **External stall:** `IN_extStall`=1 with a valid group → `OUT_stall`=1, `OUT_valid`=0, all counters unchanged.

Source files
------------

// File: rtl/sqn_allocator_pkg.sv
// sqn_allocator_pkg: shared types and constants for the sequence-number allocator.
//   SqN          - sequence number at the default width.
//   CH_ROB/LD/ST - conventional channel indices.
//   SqnGroup_t   - per-lane number vector of one channel (default widths).
package sqn_allocator_pkg;

  localparam int DEF_SQN_W = 7;
  localparam int DEF_WIDTH = 4;

  typedef logic [DEF_SQN_W-1:0] SqN;

  localparam int CH_ROB = 0;
  localparam int CH_LD  = 1;
  localparam int CH_ST  = 2;

  typedef struct packed {
    SqN [DEF_WIDTH-1:0] lane;
  } SqnGroup_t;

endpackage

// File: rtl/sqn_channel_ctr.sv
// sqn_channel_ctr: one sequence-number channel.
//   Holds alloc (next number) and head (oldest live), numbers the lanes of the
//   offered group with a prefix sum, and keeps a registered free count.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   take          - per-lane "consumes an entry of this channel"
//   fire, flush   - group accepted / mispredict flush (flush wins)
//   flush_sqn     - restored alloc value on flush
//   retire        - entries freed this cycle (applied every cycle)
//   need          - number of entries the offered group consumes
//   free          - registered free entries
//   lane_sqn      - per-lane number for the offered group
//   alloc         - registered next-allocation value
module sqn_channel_ctr
  import sqn_allocator_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int SQN_W   = 7,
  parameter int DEPTH   = 64,
  parameter bit PRE_INC = 1'b0,
  localparam int RW     = $clog2(WIDTH + 1),
  localparam int FW     = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             take,
  input  logic                         fire,
  input  logic                         flush,
  input  logic [SQN_W-1:0]             flush_sqn,
  input  logic [RW-1:0]                retire,
  output logic [RW-1:0]                need,
  output logic [FW-1:0]                free,
  output logic [WIDTH-1:0][SQN_W-1:0]  lane_sqn,
  output logic [SQN_W-1:0]             alloc
);

  logic [SQN_W-1:0] head;
  logic [SQN_W-1:0] alloc_nxt;
  logic [SQN_W-1:0] head_nxt;
  logic [SQN_W-1:0] base;
  logic [RW-1:0]    cnt;

  // Prefix-sum numbering: each lane sees alloc plus the consumers before it.
  always_comb begin
    cnt      = {RW{1'b0}};
    base     = {SQN_W{1'b0}};
    lane_sqn = '0;
    for (int i = 0; i < WIDTH; i++) begin
      base        = alloc + SQN_W'(cnt);
      lane_sqn[i] = (PRE_INC && take[i]) ? base + SQN_W'(1) : base;
      cnt         = cnt + RW'(take[i]);
    end
    need = cnt;
  end

  // Next counter values; flush overrides any allocation, retire always applies.
  always_comb begin
    if (flush) begin
      alloc_nxt = flush_sqn;
    end else if (fire) begin
      alloc_nxt = alloc + SQN_W'(need);
    end else begin
      alloc_nxt = alloc;
    end
    head_nxt = head + SQN_W'(retire);
  end

  // Counter registers; free is derived from the post-update counters (mod 2**SQN_W).
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc <= {SQN_W{1'b0}};
      head  <= {SQN_W{1'b0}};
      free  <= FW'(DEPTH);
    end else begin
      alloc <= alloc_nxt;
      head  <= head_nxt;
      free  <= FW'(DEPTH) - FW'(alloc_nxt - head_nxt);
    end
  end

  sqn_channel_chk #(
    .WIDTH (WIDTH),
    .SQN_W (SQN_W),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk    (clk),
    .rst    (rst),
    .alloc  (alloc),
    .head   (head),
    .retire (retire)
  );

endmodule

// sqn_channel_chk: simulation-only legality checks on one channel's counters.
module sqn_channel_chk #(
  parameter int WIDTH = 4,
  parameter int SQN_W = 7,
  parameter int DEPTH = 64,
  localparam int RW   = $clog2(WIDTH + 1)
) (
  input logic             clk,
  input logic             rst,
  input logic [SQN_W-1:0] alloc,
  input logic [SQN_W-1:0] head,
  input logic [RW-1:0]    retire
);

  logic [SQN_W-1:0] inflight;
  assign inflight = alloc - head;

  // Retiring more than is live, or holding more than the queue depth, is illegal.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (SQN_W'(retire) <= inflight)
        else $error("sqn_channel_chk: retire %0d exceeds inflight %0d", retire, inflight);
      assert (inflight <= SQN_W'(DEPTH))
        else $error("sqn_channel_chk: inflight %0d exceeds depth", inflight);
    end
  end

endmodule

// File: rtl/sqn_allocator.sv
// sqn_allocator: assigns ROB/load/store sequence numbers to up to WIDTH ops per
// cycle across NUM_CH channels, with all-or-nothing group acceptance.
// Packing (channel c, lane i):
//   IN_chMask[i*NUM_CH + c], IN_retire[c*RW +: RW], IN_flushSqN[c*SQN_W +: SQN_W],
//   OUT_sqN[(i*NUM_CH + c)*SQN_W +: SQN_W], OUT_next[c*SQN_W +: SQN_W],
//   OUT_free[c*FW +: FW].
// Ports: clk, rst (sync, active-high); IN_en/IN_valid/IN_chMask offer a group;
//   IN_extStall downstream stall; IN_retire freed entries; IN_flush/IN_flushSqN
//   restore; OUT_stall (combinational); OUT_valid/OUT_sqN/OUT_next/OUT_free registered.
module sqn_allocator
  import sqn_allocator_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter int              NUM_CH  = 3,
  parameter int              SQN_W   = 7,
  parameter int              DEPTH   = 64,
  parameter logic [NUM_CH-1:0] PRE_INC = NUM_CH'(1) << CH_ST,
  localparam int             RW      = $clog2(WIDTH + 1),
  localparam int             FW      = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            IN_en,
  input  logic [WIDTH-1:0]                IN_valid,
  input  logic [WIDTH*NUM_CH-1:0]         IN_chMask,
  input  logic                            IN_extStall,
  input  logic [NUM_CH*RW-1:0]            IN_retire,
  input  logic                            IN_flush,
  input  logic [NUM_CH*SQN_W-1:0]         IN_flushSqN,
  output logic                            OUT_stall,
  output logic [WIDTH-1:0]                OUT_valid,
  output logic [WIDTH*NUM_CH*SQN_W-1:0]   OUT_sqN,
  output logic [NUM_CH*SQN_W-1:0]         OUT_next,
  output logic [NUM_CH*FW-1:0]            OUT_free
);

  logic [RW-1:0]                   need     [NUM_CH];
  logic [FW-1:0]                   free     [NUM_CH];
  logic [WIDTH-1:0][SQN_W-1:0]     lane_sqn [NUM_CH];
  logic [SQN_W-1:0]                alloc    [NUM_CH];
  logic                            over;
  logic                            fire;
  logic [WIDTH*NUM_CH*SQN_W-1:0]   sqn_nxt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] take;
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      assign take[i] = IN_valid[i] & IN_chMask[i*NUM_CH + c];
    end

    sqn_channel_ctr #(
      .WIDTH   (WIDTH),
      .SQN_W   (SQN_W),
      .DEPTH   (DEPTH),
      .PRE_INC (PRE_INC[c])
    ) u_ctr (
      .clk       (clk),
      .rst       (rst),
      .take      (take),
      .fire      (fire),
      .flush     (IN_flush),
      .flush_sqn (IN_flushSqN[c*SQN_W +: SQN_W]),
      .retire    (IN_retire[c*RW +: RW]),
      .need      (need[c]),
      .free      (free[c]),
      .lane_sqn  (lane_sqn[c]),
      .alloc     (alloc[c])
    );

    assign OUT_next[c*SQN_W +: SQN_W] = alloc[c];
    assign OUT_free[c*FW +: FW]       = free[c];
  end

  // Stall if any channel lacks room; uses last cycle's free, so retire lags one cycle.
  always_comb begin
    over = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(need[c]) > int'(free[c])) begin
        over = 1'b1;
      end else begin
        over = over;
      end
    end
    OUT_stall = IN_flush | IN_extStall | (IN_en & over);
    fire      = IN_en & ~OUT_stall;
  end

  // Repack per-channel lane numbers into lane-major output order.
  always_comb begin
    sqn_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sqn_nxt[(i*NUM_CH + c)*SQN_W +: SQN_W] = lane_sqn[c][i];
      end
    end
  end

  // Output group registers; numbers hold when nothing is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      OUT_valid <= {WIDTH{1'b0}};
      OUT_sqN   <= '0;
    end else begin
      OUT_valid <= fire ? IN_valid : {WIDTH{1'b0}};
      if (fire) begin
        OUT_sqN <= sqn_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sqn_allocator.sv
module tb_sqn_allocator;
  import sqn_allocator_pkg::*;

  localparam int W  = 4;
  localparam int C  = 3;
  localparam int S  = 7;
  localparam int D  = 64;
  localparam int RW = 3;
  localparam int FW = 7;
  localparam logic [C-1:0] PI = 3'b100;
  localparam logic [W*C-1:0] M_ROB  = 12'b001_001_001_001;
  localparam logic [W*C-1:0] M_GRP1 = 12'b101_011_011_001;

  logic               clk = 1'b0;
  logic               rst;
  logic               IN_en;
  logic [W-1:0]       IN_valid;
  logic [W*C-1:0]     IN_chMask;
  logic               IN_extStall;
  logic [C*RW-1:0]    IN_retire;
  logic               IN_flush;
  logic [C*S-1:0]     IN_flushSqN;
  logic               OUT_stall;
  logic [W-1:0]       OUT_valid;
  logic [W*C*S-1:0]   OUT_sqN;
  logic [C*S-1:0]     OUT_next;
  logic [C*FW-1:0]    OUT_free;

  sqn_allocator dut (
    .clk(clk), .rst(rst), .IN_en(IN_en), .IN_valid(IN_valid), .IN_chMask(IN_chMask),
    .IN_extStall(IN_extStall), .IN_retire(IN_retire), .IN_flush(IN_flush),
    .IN_flushSqN(IN_flushSqN), .OUT_stall(OUT_stall), .OUT_valid(OUT_valid),
    .OUT_sqN(OUT_sqN), .OUT_next(OUT_next), .OUT_free(OUT_free)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]     valid;
    logic [W*C*S-1:0] sqn;
    logic [C*S-1:0]   nxt;
    logic [C*FW-1:0]  free;
  } exp_t;
  exp_t sb[$];

  logic [S-1:0]     m_alloc [C];
  logic [S-1:0]     m_head  [C];
  logic [W*C*S-1:0] m_sqn;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [S-1:0] lane(input int i, input int c);
    return OUT_sqN[(i*C + c)*S +: S];
  endfunction

  task automatic reset_model();
    for (int c = 0; c < C; c++) begin
      m_alloc[c] = '0;
      m_head[c]  = '0;
    end
    m_sqn = '0;
    sb.delete();
  endtask

  task automatic idle_inputs();
    IN_en = 1'b0; IN_valid = '0; IN_chMask = '0; IN_extStall = 1'b0;
    IN_retire = '0; IN_flush = 1'b0; IN_flushSqN = '0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, OUT_valid, 0);
    chk({tag, "_sqn"},   OUT_sqN, 0);
    chk({tag, "_next"},  OUT_next, 0);
    chk({tag, "_free"},  OUT_free, {7'd64, 7'd64, 7'd64});
  endtask

  // One cycle: drive, check stall against model, predict, clock, compare.
  task automatic step(input logic en, input logic [W-1:0] v, input logic [W*C-1:0] mk,
                      input logic xs, input logic [C*RW-1:0] ret,
                      input logic fl, input logic [C*S-1:0] fsq);
    int need [C];
    int freec;
    logic stall, fire, use_l;
    logic [S-1:0] inf, base, cnt;
    exp_t e;
    IN_en = en; IN_valid = v; IN_chMask = mk; IN_extStall = xs;
    IN_retire = ret; IN_flush = fl; IN_flushSqN = fsq;
    #1;
    stall = fl || xs;
    for (int c = 0; c < C; c++) begin
      need[c] = 0;
      for (int i = 0; i < W; i++) if (v[i] && mk[i*C + c]) need[c]++;
      inf   = m_alloc[c] - m_head[c];
      freec = D - int'(inf);
      if (en && need[c] > freec) stall = 1'b1;
    end
    chk("stall", OUT_stall, stall);
    fire = en && !stall;
    if (fire) begin
      for (int c = 0; c < C; c++) begin
        cnt = '0;
        for (int i = 0; i < W; i++) begin
          use_l = v[i] && mk[i*C + c];
          base  = m_alloc[c] + cnt;
          m_sqn[(i*C + c)*S +: S] = (PI[c] && use_l) ? base + S'(1) : base;
          if (use_l) cnt = cnt + S'(1);
        end
      end
    end
    for (int c = 0; c < C; c++) begin
      if (fl) m_alloc[c] = fsq[c*S +: S];
      else if (fire) m_alloc[c] = m_alloc[c] + S'(need[c]);
      m_head[c] = m_head[c] + S'(ret[c*RW +: RW]);
    end
    e.valid = fire ? v : '0;
    e.sqn   = m_sqn;
    for (int c = 0; c < C; c++) begin
      e.nxt[c*S +: S]   = m_alloc[c];
      e.free[c*FW +: FW] = FW'(D) - FW'(m_alloc[c] - m_head[c]);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("valid", OUT_valid, e.valid);
    chk("sqn",   OUT_sqN,   e.sqn);
    chk("next",  OUT_next,  e.nxt);
    chk("free",  OUT_free,  e.free);
  endtask

  logic [S-1:0] rob_exp [W];
  logic [S-1:0] ld_exp  [W];
  logic [S-1:0] st_exp  [W];

  initial begin
    idle_inputs();
    reset_model();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    chk("reset_stall", OUT_stall, 1'b0);
    rst = 1'b0;

    // Reset then group
    step(1'b1, 4'b1111, M_GRP1, 1'b0, '0, 1'b0, '0);
    rob_exp = '{7'd0, 7'd1, 7'd2, 7'd3};
    ld_exp  = '{7'd0, 7'd0, 7'd1, 7'd2};
    st_exp  = '{7'd0, 7'd0, 7'd0, 7'd1};
    for (int i = 0; i < W; i++) begin
      chk($sformatf("grp1_rob%0d", i), lane(i, CH_ROB), rob_exp[i]);
      chk($sformatf("grp1_ld%0d", i),  lane(i, CH_LD),  ld_exp[i]);
      chk($sformatf("grp1_st%0d", i),  lane(i, CH_ST),  st_exp[i]);
    end
    chk("grp1_next", OUT_next, {7'd1, 7'd2, 7'd4});

    // Fill ROB to 62 inflight, then exactly-full 2-lane group
    for (int k = 0; k < 14; k++) step(1'b1, 4'b1111, M_ROB, 1'b0, '0, 1'b0, '0);
    step(1'b1, 4'b0011, M_ROB, 1'b0, '0, 1'b0, '0);
    chk("fill62_free", OUT_free[CH_ROB*FW +: FW], 7'd2);
    step(1'b1, 4'b0011, M_ROB, 1'b0, '0, 1'b0, '0);
    chk("full_valid", OUT_valid, 4'b0011);
    chk("full_free", OUT_free[CH_ROB*FW +: FW], 7'd0);
    step(1'b1, 4'b0001, M_ROB, 1'b0, '0, 1'b0, '0);
    chk("over_valid", OUT_valid, 4'b0000);
    chk("over_next", OUT_next[CH_ROB*S +: S], 7'd64);

    // Retire visibility: same-cycle retire does not relieve the stall
    step(1'b1, 4'b0001, M_ROB, 1'b0, 9'd2, 1'b0, '0);
    chk("ret_same_valid", OUT_valid, 4'b0000);
    step(1'b1, 4'b0001, M_ROB, 1'b0, '0, 1'b0, '0);
    chk("ret_next_valid", OUT_valid, 4'b0001);
    chk("ret_next_sqn", lane(0, CH_ROB), 7'd64);
    chk("ret_next_free", OUT_free[CH_ROB*FW +: FW], 7'd1);

    // Flush priority with simultaneous retire
    step(1'b1, 4'b0001, M_ROB, 1'b0, 9'd1, 1'b1, {7'd5, 7'd3, 7'd10});
    chk("flush_valid", OUT_valid, 4'b0000);
    chk("flush_next", OUT_next, {7'd5, 7'd3, 7'd10});
    step(1'b1, 4'b0001, M_ROB, 1'b0, '0, 1'b0, '0);
    chk("post_flush_sqn", lane(0, CH_ROB), 7'd10);

    // Move ROB to alloc=126, head=100
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, {7'd5, 7'd3, 7'd64});
    for (int k = 0; k < 8; k++) step(1'b0, '0, '0, 1'b0, 9'd7, 1'b0, '0);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, {7'd5, 7'd3, 7'd100});
    for (int k = 0; k < 5; k++) step(1'b0, '0, '0, 1'b0, 9'd7, 1'b0, '0);
    step(1'b0, '0, '0, 1'b0, 9'd6, 1'b0, '0);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, {7'd5, 7'd3, 7'd126});
    chk("prewrap_free", OUT_free[CH_ROB*FW +: FW], 7'd38);

    // Wrap-around
    step(1'b1, 4'b1111, M_ROB, 1'b0, '0, 1'b0, '0);
    rob_exp = '{7'd126, 7'd127, 7'd0, 7'd1};
    for (int i = 0; i < W; i++) chk($sformatf("wrap_rob%0d", i), lane(i, CH_ROB), rob_exp[i]);
    chk("wrap_next", OUT_next[CH_ROB*S +: S], 7'd2);
    chk("wrap_free", OUT_free[CH_ROB*FW +: FW], 7'd34);

    // External stall
    step(1'b1, 4'b1111, M_ROB, 1'b1, '0, 1'b0, '0);
    chk("xs_valid", OUT_valid, 4'b0000);
    chk("xs_next", OUT_next, {7'd5, 7'd3, 7'd2});
    chk("xs_free", OUT_free[CH_ROB*FW +: FW], 7'd34);
    chk("xs_sqn_hold", lane(3, CH_ROB), 7'd1);

    // Reset mid-group
    IN_en = 1'b1; IN_valid = 4'b1111; IN_chMask = M_GRP1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("midrst");
    rst = 1'b0;
    idle_inputs();
    reset_model();
    step(1'b1, 4'b1111, M_GRP1, 1'b0, '0, 1'b0, '0);
    chk("after_rst_rob3", lane(3, CH_ROB), 7'd3);
    chk("after_rst_st3", lane(3, CH_ST), 7'd1);

    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
